sized_data_memory: RTL and testbench

Byte-addressed, big-endian data memory for the ARM datapath's MEM stage. It replaces the fixed 64-bit double-word memory with parameterised depth, data width and read latency. It adds byte, half, word and double-word access sizes with zero or sign extension, a pipelined read-valid path, and fault reporting for misaligned, out-of-range and conflicting requests. One request is accepted per cycle and the block never stalls.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_read_pipe.sv | 58 +++++
 rtl/sized_data_memory.sv | 137 +++++++++++++
 tb/tb_sized_data_memory.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for sized_data_memory: access sizes, fault codes and the
// size-to-byte-count helper.
package dmem_pkg;

  // Access size encodings (byte count is 2^Size)
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  // FaultCode encodings
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_ALIGN    = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;
  localparam logic [1:0] FLT_CONFLICT = 2'b11;

  // Number of bytes touched by an access of the given size
  function automatic int unsigned size_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_read_pipe.sv
// RD_LAT-deep result pipeline carrying {valid, fault, code, data}.
// The last stage only reloads its data on a valid read, so the visible
// read data holds its last good value between ReadValid pulses.
module dmem_read_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              ResetL,
  input  logic              in_valid,
  input  logic              in_fault,
  input  logic [1:0]        in_code,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_fault,
  output logic [1:0]        out_code,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] fault_q;
  logic [1:0]        code_q [RD_LAT];
  logic [DATA_W-1:0] data_q [RD_LAT];

  // Shift every stage by one per cycle; reset drops anything in flight
  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      valid_q <= '0;
      fault_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        code_q[i] <= 2'b00;
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      fault_q[0] <= in_fault;
      code_q[0]  <= in_code;
      if (RD_LAT > 1 || in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(RD_LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        fault_q[i] <= fault_q[i-1];
        code_q[i]  <= code_q[i-1];
        // Final stage is the output register: hold it unless a read arrives
        if (i < int'(RD_LAT) - 1 || valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_fault = fault_q[RD_LAT-1];
  assign out_code  = code_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed big-endian data memory with byte/half/word/double accesses,
// zero/sign extension, pipelined read return and fault reporting.
// Optional macro DMEM_ALIGN_CHECK_EN makes misaligned accesses fault (code 01);
// without it they complete byte-wise at Address..Address+n-1.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              ResetL,
  input  logic              MemoryRead,
  input  logic              MemoryWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [1:0]        Size,
  input  logic              SignExtend,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic              Fault,
  output logic [1:0]        FaultCode
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AW1   = ADDR_W + 1;

  logic [7:0] mem [DEPTH];

  logic [3:0]        n_bytes;
  logic [3:0]        n_m1;
  logic              req;
  logic [AW1-1:0]    end_addr;
  logic              range_bad;
  logic              size_bad;
  logic              misalign;
  logic              align_bad;
  logic [1:0]        code;
  logic              fault;
  logic              do_write;
  logic              do_read;
  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  byte_idx [NB];
  logic [DATA_W-1:0] raw;
  logic              sign;
  logic [DATA_W-1:0] ext;

  assign n_bytes = 4'(size_bytes(Size));
  assign n_m1    = n_bytes - 4'd1;
  assign req     = MemoryRead | MemoryWrite;
  // One extra bit so Address+n never wraps
  assign end_addr  = {1'b0, Address} + AW1'(n_bytes);
  assign range_bad = end_addr > AW1'(DEPTH);
  assign size_bad  = 32'(n_bytes) > NB;
  assign misalign  = |(Address[2:0] & n_m1[2:0]);
  assign base      = Address[IDX_W-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_bad = size_bad | misalign;
`else
  assign align_bad = size_bad;
`endif

  // Fault priority: conflict, then range, then alignment/size
  always_comb begin
    code = FLT_NONE;
    if (MemoryRead && MemoryWrite) begin
      code = FLT_CONFLICT;
    end else if (req && range_bad) begin
      code = FLT_RANGE;
    end else if (req && align_bad) begin
      code = FLT_ALIGN;
    end
  end

  assign fault    = code != FLT_NONE;
  assign do_write = ResetL & MemoryWrite & ~fault;
  assign do_read  = MemoryRead & ~fault;

  // Byte i of the right-justified value lives at Address+n-1-i (big-endian)
  always_comb begin
    for (int i = 0; i < int'(NB); i++) begin
      byte_idx[i] = IDX_W'(int'(base) + int'(n_bytes) - 1 - i);
    end
  end

  // Storage has no reset; only bytes covered by a good write change
  always_ff @(posedge Clock) begin
    if (do_write) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (i < int'(n_bytes)) begin
          mem[byte_idx[i]] <= WriteData[8*i +: 8];
        end
      end
    end
  end

  // Assemble the read value right-justified and extend above bit 8n-1
  always_comb begin
    raw  = '0;
    sign = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      if (i < int'(n_bytes)) begin
        raw[8*i +: 8] = mem[byte_idx[i]];
      end
      if (i == int'(n_bytes) - 1) begin
        sign = mem[byte_idx[i]][7];
      end
    end
    ext = raw;
    for (int b = 0; b < int'(DATA_W); b++) begin
      if (b >= 8 * int'(n_bytes)) begin
        ext[b] = SignExtend & sign;
      end
    end
  end

  dmem_read_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_read_pipe (
    .Clock     (Clock),
    .ResetL    (ResetL),
    .in_valid  (do_read),
    .in_fault  (fault),
    .in_code   (code),
    .in_data   (ext),
    .out_valid (ReadValid),
    .out_fault (Fault),
    .out_code  (FaultCode),
    .out_data  (ReadData)
  );

endmodule

// File: tb/tb_sized_data_memory.sv
// Scoreboard bench for sized_data_memory (RD_LAT=3): a driver issues directed
// requests and queues expected outputs; a monitor pops and compares each
// ReadValid/Fault pulse, including its arrival cycle.
module tb_sized_data_memory;
  import dmem_pkg::*;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned RD_LAT = 3;

  logic              Clock;
  logic              ResetL;
  logic              MemoryRead;
  logic              MemoryWrite;
  logic [ADDR_W-1:0] Address;
  logic [1:0]        Size;
  logic              SignExtend;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              ReadValid;
  logic              Fault;
  logic [1:0]        FaultCode;

  sized_data_memory #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clock       (Clock),
    .ResetL      (ResetL),
    .MemoryRead  (MemoryRead),
    .MemoryWrite (MemoryWrite),
    .Address     (Address),
    .Size        (Size),
    .SignExtend  (SignExtend),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .ReadValid   (ReadValid),
    .Fault       (Fault),
    .FaultCode   (FaultCode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic [63:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;

  localparam logic [63:0] DW = 64'h0FFB_EA7D_EADB_EEFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    forever begin
      exp_t e;
      @(posedge Clock);
      edges++;
      #1;
      if (ReadValid === 1'b1 || Fault === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: ReadValid=%b Fault=%b code=%b data=%h", ReadValid,
                   Fault, FaultCode, ReadData);
        end else begin
          e = sb.pop_front();
          check({e.name, "_kind"}, 64'({ReadValid, Fault}), e.is_fault ? 64'd1 : 64'd2);
          check({e.name, "_code"}, 64'(FaultCode), 64'(e.code));
          if (!e.is_fault) check({e.name, "_data"}, ReadData, e.data);
          check({e.name, "_cycle"}, 64'(edges), 64'(e.due));
        end
      end
    end
  end

  // kind: 0 no output expected, 1 read data, 2 fault
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [63:0] addr, input logic [63:0] wd, input int kind,
                       input logic [1:0] code, input logic [63:0] data, input string name);
    exp_t e;
    @(negedge Clock);
    MemoryRead  = rd;
    MemoryWrite = wr;
    Size        = sz;
    SignExtend  = sx;
    Address     = addr;
    WriteData   = wd;
    if (kind != 0) begin
      e.is_fault = (kind == 2);
      e.code     = code;
      e.data     = data;
      e.due      = edges + int'(RD_LAT);
      e.name     = name;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd);
    issue(1'b0, 1'b1, sz, 1'b0, addr, wd, 0, FLT_NONE, 64'd0, "wr");
  endtask

  task automatic rd(input logic [1:0] sz, input logic sx, input logic [63:0] addr,
                    input logic [63:0] exp_data, input string name);
    issue(1'b1, 1'b0, sz, sx, addr, 64'd0, 1, FLT_NONE, exp_data, name);
  endtask

  task automatic flt(input logic r, input logic w, input logic [1:0] sz, input logic [63:0] addr,
                     input logic [1:0] code, input string name);
    issue(r, w, sz, 1'b0, addr, 64'd0, 2, code, 64'd0, name);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      MemoryRead  = 1'b0;
      MemoryWrite = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    idle(1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge Clock);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_rv"}, 64'(ReadValid), 64'd0);
    check({name, "_flt"}, 64'(Fault), 64'd0);
    check({name, "_data"}, ReadData, 64'd0);
  endtask

  initial begin
    ResetL      = 1'b0;
    MemoryRead  = 1'b1;
    MemoryWrite = 1'b0;
    Address     = 64'h18;
    Size        = SZ_DOUBLE;
    SignExtend  = 1'b0;
    WriteData   = '0;

    // Read held during reset must never surface
    repeat (3) begin
      @(negedge Clock);
      check_quiet("reset_hold");
    end
    @(negedge Clock);
    ResetL     = 1'b1;
    MemoryRead = 1'b0;

    // Double-word round trip and sub-word reads
    wr(SZ_DOUBLE, 64'h18, DW);
    rd(SZ_DOUBLE, 1'b0, 64'h18, DW, "dw_rt");
    rd(SZ_BYTE, 1'b0, 64'h18, 64'h0F, "byte_msb");
    rd(SZ_BYTE, 1'b0, 64'h1F, 64'hFF, "byte_lsb");
    rd(SZ_HALF, 1'b1, 64'h1C, 64'hFFFF_FFFF_FFFF_EADB, "half_sx");
    rd(SZ_HALF, 1'b0, 64'h1C, 64'h0000_0000_0000_EADB, "half_zx");
    rd(SZ_WORD, 1'b1, 64'h1C, 64'hFFFF_FFFF_EADB_EEFF, "word_sx");
    rd(SZ_BYTE, 1'b1, 64'h1F, 64'hFFFF_FFFF_FFFF_FFFF, "byte_sx");

    // Conflict leaves memory untouched
    issue(1'b1, 1'b1, SZ_DOUBLE, 1'b0, 64'h18, 64'd0, 2, FLT_CONFLICT, 64'd0, "conflict");
    rd(SZ_DOUBLE, 1'b0, 64'h18, DW, "after_conflict");

    // Range boundaries
    flt(1'b1, 1'b0, SZ_DOUBLE, 64'(DEPTH - 4), FLT_RANGE, "range_dw");
    wr(SZ_BYTE, 64'(DEPTH - 1), 64'h5A);
    rd(SZ_BYTE, 1'b0, 64'(DEPTH - 1), 64'h5A, "top_byte");
    flt(1'b0, 1'b1, SZ_BYTE, 64'(DEPTH), FLT_RANGE, "range_wr");
    flt(1'b1, 1'b0, SZ_BYTE, 64'hFFFF_FFFF_FFFF_FFFF, FLT_RANGE, "range_nowrap");

    // Partial write
    wr(SZ_DOUBLE, 64'h8, 64'h0A);
    wr(SZ_BYTE, 64'h9, 64'hAB);
    rd(SZ_DOUBLE, 1'b0, 64'h8, 64'h00AB_0000_0000_000A, "partial");

    // Misaligned accesses
    wr(SZ_DOUBLE, 64'h0, 64'h0011_2233_4455_6677);
`ifdef DMEM_ALIGN_CHECK_EN
    flt(1'b1, 1'b0, SZ_WORD, 64'h2, FLT_ALIGN, "misalign_rd");
    flt(1'b0, 1'b1, SZ_HALF, 64'h1, FLT_ALIGN, "misalign_wr");
    rd(SZ_DOUBLE, 1'b0, 64'h0, 64'h0011_2233_4455_6677, "misalign_mem");
`else
    rd(SZ_WORD, 1'b0, 64'h2, 64'h2233_4455, "misalign_rd");
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 64'h1, 64'hBEEF, 0, FLT_NONE, 64'd0, "misalign_wr");
    rd(SZ_DOUBLE, 1'b0, 64'h0, 64'h00BE_EF33_4455_6677, "misalign_mem");
`endif
    wr(SZ_BYTE, 64'h0, 64'h80);
    rd(SZ_BYTE, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, "byte_sx80");
    drain("drain1");

    // Write then immediate read, then five back-to-back reads
    wr(SZ_DOUBLE, 64'h20, 64'h1234);
    rd(SZ_DOUBLE, 1'b0, 64'h20, 64'h1234, "lat_rd");
    rd(SZ_DOUBLE, 1'b0, 64'h18, DW, "b2b_0");
    rd(SZ_BYTE, 1'b0, 64'h18, 64'h0F, "b2b_1");
    rd(SZ_BYTE, 1'b0, 64'h1F, 64'hFF, "b2b_2");
    rd(SZ_DOUBLE, 1'b0, 64'h20, 64'h1234, "b2b_3");
    rd(SZ_DOUBLE, 1'b0, 64'h8, 64'h00AB_0000_0000_000A, "b2b_4");
    drain("drain2");
    idle(2);
    check("hold_data", ReadData, 64'h00AB_0000_0000_000A);

    // Reset with a read in flight; a write during reset is ignored
    issue(1'b1, 1'b0, SZ_DOUBLE, 1'b0, 64'h20, 64'd0, 0, FLT_NONE, 64'd0, "inflight");
    @(negedge Clock);
    ResetL      = 1'b0;
    MemoryRead  = 1'b0;
    MemoryWrite = 1'b1;
    Address     = 64'h18;
    Size        = SZ_DOUBLE;
    WriteData   = 64'd0;
    repeat (2) begin
      @(negedge Clock);
      check_quiet("reset_inflight");
    end
    ResetL      = 1'b1;
    MemoryWrite = 1'b0;
    idle(5);
    check("post_reset_data", ReadData, 64'd0);
    rd(SZ_DOUBLE, 1'b0, 64'h18, DW, "reset_no_write");
    drain("drain3");
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
